// File: rtl/seq_pkg.sv
// Shared types and sizes for the seq_playback LED sequencer.
// Holds the playback state enum, word/element sizes and the element-select helper.
package seq_pkg;

  localparam int NIBBLE_W = 4;
  localparam int WORD_W   = 64;
  localparam int MAX_ELEM = 16;
  localparam int STEP_W   = $clog2(MAX_ELEM);
  localparam int CNT_W    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Element k lives in bits [4k+3:4k] of the packed sequence word.
  function automatic logic [NIBBLE_W-1:0] elem_of(input logic [WORD_W-1:0] word,
                                                  input logic [STEP_W-1:0] idx);
    return word[idx*NIBBLE_W +: NIBBLE_W];
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter with a zero flag; a load of N makes zero rise after N cycles
// (counter holds N-1 and stops at 0, so it never wraps).
module seq_timer
  import seq_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= (load_val == '0) ? '0 : load_val - 1'b1;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/seq_playback.sv
// Plays up to 16 packed 4-bit patterns on led, each for ON_CYCLES then blanked for OFF_CYCLES.
// Build macro SEQ_PLAYBACK_GAP_EN enables the blank OFF gap; without it elements play back to back.
module seq_playback
  import seq_pkg::*;
#(
  parameter int ON_CYCLES  = 50,
  parameter int OFF_CYCLES = 25
) (
  input  logic                clk,
  input  logic                R,
  input  logic                start,
  input  logic                abort,
  input  logic [STEP_W-1:0]   len,
  input  logic [WORD_W-1:0]   data,
  output logic [NIBBLE_W-1:0] led,
  output logic [STEP_W-1:0]   step,
  output logic                busy,
  output logic                done,
  output logic [NIBBLE_W-1:0] mvp,
  output state_t              dbg_state
);

  // start is a level request with no ready: it is taken only in IDLE (and only with abort low),
  // acceptance shows as busy on the following cycle; abort is honoured in every state.

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [STEP_W-1:0]   len_q;
  logic [WORD_W-1:0]   word_q;
  logic                capture;
  logic                timer_load;
  logic [CNT_W-1:0]    timer_val;
  logic                timer_zero;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = ON;
          step_d  = '0;
          capture = 1'b1;
        end
      end
      ON: begin
        if (abort) begin
          state_d = IDLE;
          step_d  = '0;
        end else if (timer_zero) begin
`ifdef SEQ_PLAYBACK_GAP_EN
          state_d = OFF;
`else
          if (step_q == len_q) begin
            state_d = DONE;
          end else begin
            state_d = ON;
            step_d  = step_q + 1'b1;
          end
`endif
        end
      end
`ifdef SEQ_PLAYBACK_GAP_EN
      OFF: begin
        if (abort) begin
          state_d = IDLE;
          step_d  = '0;
        end else if (timer_zero) begin
          if (step_q == len_q) begin
            state_d = DONE;
          end else begin
            state_d = ON;
            step_d  = step_q + 1'b1;
          end
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
        step_d  = '0;
      end
      default: begin
        state_d = IDLE;
        step_d  = '0;
      end
    endcase
  end

  // Every state entry (including ON->ON on a new element) reloads the duration counter.
  always_comb begin
    timer_load = (state_d != state_q) || (step_d != step_q);
    case (state_d)
      ON:      timer_val = CNT_W'(ON_CYCLES);
      OFF:     timer_val = CNT_W'(OFF_CYCLES);
      default: timer_val = CNT_W'(1);
    endcase
  end

  seq_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (R),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state_q <= IDLE;
      step_q  <= '0;
      len_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      if (capture) begin
        len_q  <= len;
        word_q <= data;
      end
    end
  end

  assign led       = (state_q == ON) ? elem_of(word_q, step_q) : '0;
  assign step      = step_q;
  assign busy      = (state_q == ON) || (state_q == OFF);
  assign done      = (state_q == DONE);
  assign mvp       = word_q[WORD_W-1 -: NIBBLE_W];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_playback.sv
// Bench for seq_playback with ON_CYCLES=3, OFF_CYCLES=2: directed table, hand-written
// abort/reset/held-start sequences and random runs, all against a per-cycle expected stream.
module tb_seq_playback;
  import seq_pkg::*;

  localparam int ON_C  = 3;
  localparam int OFF_C = 2;
`ifdef SEQ_PLAYBACK_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif
  localparam int OFF_E = GAP ? OFF_C : 0;

  logic        clk;
  logic        R;
  logic        start;
  logic        abort;
  logic [3:0]  len;
  logic [63:0] data;
  logic [3:0]  led;
  logic [3:0]  step;
  logic        busy;
  logic        done;
  logic [3:0]  mvp;
  state_t      dbg_state;

  seq_playback #(.ON_CYCLES(ON_C), .OFF_CYCLES(OFF_C)) dut (
    .clk       (clk),
    .R         (R),
    .start     (start),
    .abort     (abort),
    .len       (len),
    .data      (data),
    .led       (led),
    .step      (step),
    .busy      (busy),
    .done      (done),
    .mvp       (mvp),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [9:0] exp_q[$];  // {led, step, busy, done} per cycle after the start edge

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference: each element shown ON_C cycles, then OFF_E blank cycles, then one done cycle, then idle.
  function automatic void build_expected(input logic [63:0] d, input logic [3:0] l);
    exp_q.delete();
    for (int k = 0; k <= int'(l); k++) begin
      logic [3:0] e;
      e = 4'((d >> (4 * k)) & 64'hF);
      repeat (ON_C)  exp_q.push_back({e, 4'(k), 1'b1, 1'b0});
      repeat (OFF_E) exp_q.push_back({4'h0, 4'(k), 1'b1, 1'b0});
    end
    exp_q.push_back({4'h0, l, 1'b0, 1'b1});
    exp_q.push_back(10'h0);
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge with the DUT idle; returns at a negedge.
  task automatic play(input string name, input logic [63:0] d, input logic [3:0] l,
                      input bit hold, input int abort_at, input int reset_at,
                      output int busy_n, output int done_at);
    int n;
    logic [9:0] e;
    build_expected(d, l);
    n = exp_q.size();
    busy_n  = 0;
    done_at = 0;
    start = 1'b1;
    data  = d;
    len   = l;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("%s cyc%0d led/step/busy/done", name, c),
            64'({led, step, busy, done}), 64'(e));
      if (busy) busy_n++;
      if (done) done_at = c;
      if (c == 1) check({name, " mvp"}, 64'(mvp), 64'(d[63:60]));
      // Start pulses mid-run must be ignored; data/len changes must not matter.
      start = (c == n) ? hold : (hold ? 1'b1 : 1'($urandom_range(0, 1)));
      data  = {$urandom, $urandom};
      len   = 4'($urandom_range(0, 15));
      if (c == abort_at) begin
        abort = 1'b1;
        start = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        check({name, " outputs after abort"}, 64'({led, step, busy, done}), 64'd0);
        check({name, " state after abort"}, 64'(dbg_state), 64'(IDLE));
        repeat (8) begin
          @(negedge clk);
          check({name, " quiet after abort"}, 64'({done, busy}), 64'd0);
        end
        return;
      end
      if (c == reset_at) begin
        R = 1'b0;
        #1;
        check({name, " async reset outputs"}, 64'({led, step, busy, done, mvp}), 64'd0);
        check({name, " async reset state"}, 64'(dbg_state), 64'(IDLE));
        return;
      end
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [63:0] d;
    logic [3:0]  l;
    int          busy;
    logic [3:0]  mvp;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int bn, da;
    vecs[0] = '{64'hA000_0000_0000_4321, 4'd3,  GAP ? 20 : 12, 4'hA};
    vecs[1] = '{64'hFEDC_BA98_7654_3210, 4'd15, GAP ? 80 : 48, 4'hF};
    vecs[2] = '{64'h0000_0000_0000_0021, 4'd1,  GAP ? 10 : 6,  4'h0};
    vecs[3] = '{64'h0000_0000_0000_0005, 4'd0,  GAP ? 5  : 3,  4'h0};

    R = 1'b0; start = 1'b0; abort = 1'b0; data = '0; len = '0;
    repeat (2) @(negedge clk);
    check("reset outputs", 64'({led, step, busy, done, mvp}), 64'd0);
    check("reset state", 64'(dbg_state), 64'(IDLE));
    R = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      play($sformatf("vec%0d", i), vecs[i].d, vecs[i].l, 1'b0, 0, 0, bn, da);
      check($sformatf("vec%0d busy cycles", i), 64'(bn), 64'(vecs[i].busy));
      check($sformatf("vec%0d done cycle", i), 64'(da), 64'(vecs[i].busy + 1));
      check($sformatf("vec%0d mvp held", i), 64'(mvp), 64'(vecs[i].mvp));
    end

    // Abort in the second cycle of element 1's ON phase.
    play("abort", 64'h0000_0000_0000_4321, 4'd3, 1'b0, ON_C + OFF_E + 2, 0, bn, da);

    // start and abort together in IDLE: nothing captured, stays idle.
    start = 1'b1; abort = 1'b1; data = 64'hB000_0000_0000_0777; len = 4'd2;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start+abort busy", 64'(busy), 64'd0);
    check("start+abort mvp", 64'(mvp), 64'd0);
    check("start+abort state", 64'(dbg_state), 64'(IDLE));
    @(negedge clk);
    check("start+abort still idle", 64'({busy, done}), 64'd0);

    // Reset in the middle of element 2 (its OFF phase when the gap exists).
    play("reset_mid", 64'hC000_0000_0000_4321, 4'd3, 1'b0, 0,
         GAP ? (2 * (ON_C + OFF_E) + ON_C + 1) : (2 * ON_C + 2), bn, da);
    @(negedge clk);
    check("reset held outputs", 64'({led, step, busy, done, mvp}), 64'd0);
    R = 1'b1;  // start is presented for the first edge with R high
    play("after_reset", 64'h9000_0000_0000_8765, 4'd3, 1'b0, 0, 0, bn, da);
    check("after_reset busy cycles", 64'(bn), 64'(4 * (ON_C + OFF_E)));

    // start held through a run with data scrambled mid-run; second run follows DONE.
    play("hold1", 64'h5000_0000_0000_0ABC, 4'd2, 1'b1, 0, 0, bn, da);
    check("hold1 busy cycles", 64'(bn), 64'(3 * (ON_C + OFF_E)));
    play("hold2", 64'h6000_0000_0000_00DE, 4'd1, 1'b0, 0, 0, bn, da);
    check("hold2 done cycle", 64'(da), 64'(2 * (ON_C + OFF_E) + 1));

    // Random runs.
    for (int r = 0; r < 6; r++) begin
      logic [63:0] rd;
      logic [3:0]  rl;
      rd = {$urandom, $urandom};
      rl = 4'($urandom_range(0, 15));
      play($sformatf("rand%0d", r), rd, rl, 1'b0, 0, 0, bn, da);
      check($sformatf("rand%0d busy cycles", r), 64'(bn), 64'((int'(rl) + 1) * (ON_C + OFF_E)));
      check($sformatf("rand%0d done cycle", r), 64'(da), 64'((int'(rl) + 1) * (ON_C + OFF_E) + 1));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/seq_playback.md
SEQ_PLAYBACK -- requirements
Module: seq_playback

Interface
REQ-001 Parameter ON_CYCLES, default 50: clock cycles each element is shown on led; legal range 1..65535.
REQ-002 Parameter OFF_CYCLES, default 25: blank cycles after each element; legal range 1..65535.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 R  in  1  reset; asynchronous and active-low.
REQ-005 start  in  1  request playback; sampled only in IDLE.
REQ-006 abort  in  1  cancel playback; sampled in every state.
REQ-007 len  in  4  last element index; the block plays len+1 elements (1..16).
REQ-008 data  in  64  packed sequence word; element k = data[4k+3:4k].
REQ-009 led  out  4  current element pattern; 0 when blank.
REQ-010 step  out  4  index of the element being shown.
REQ-011 busy  out  1  high in the ON and OFF states only.
REQ-012 done  out  1  one-cycle pulse on normal completion.
REQ-013 mvp  out  4  data[63:60] captured at start, held until the next start or reset.

Function
REQ-014 States: IDLE, ON, OFF, DONE.
REQ-015 IDLE with start=1 and abort=0: capture data, len and mvp.
- Then go to ON with step=0 on the next edge.
REQ-016 Latency: start sampled at edge t; busy=1 and led=element 0 from cycle t+1.
REQ-017 ON: led=element[step] for exactly ON_CYCLES cycles, then go to OFF.
REQ-018 OFF: led=0 for exactly OFF_CYCLES cycles.
- step<len: increment step and go to ON.
- step==len: go to DONE.
REQ-019 DONE: lasts one cycle with done=1, busy=0, led=0; then go to IDLE.
REQ-020 Total busy duration SHALL be (len+1)*(ON_CYCLES+OFF_CYCLES) cycles.
REQ-021 abort=1 in ON or OFF: go to IDLE on the next edge; led=0, step=0, done never asserted.
REQ-022 abort=1 in DONE: the done pulse still completes; the transition to IDLE is unchanged.
REQ-023 start and abort both high in IDLE: abort wins; the block stays in IDLE and captures nothing.
REQ-024 start in ON, OFF or DONE: ignored, with no queuing.
REQ-025 Changes on data or len while busy SHALL NOT affect playback; only the captured copies are used.
REQ-026 The duration counter SHALL reload on every state entry and never wrap.
REQ-027 step SHALL never exceed the captured len.

Reset
REQ-028 R low, at any time including mid-playback: state=IDLE, led=0, step=0, busy=0, done=0, mvp=0, captured word=0, counter=0.
REQ-029 Release of R: the first start is accepted on the first rising edge with R high.

Configuration
REQ-030 Macro SEQ_PLAYBACK_GAP_EN defined: the OFF state exists as specified.
REQ-031 Macro SEQ_PLAYBACK_GAP_EN undefined: OFF is removed and OFF_CYCLES is ignored.
- ON goes directly to the next ON (step+1).
- The last element goes from ON to DONE.
- Total busy duration = (len+1)*ON_CYCLES.

Structure
REQ-032 Shared package seq_pkg SHALL hold:
- the state enum (IDLE/ON/OFF/DONE);
- NIBBLE_W=4, WORD_W=64, MAX_ELEM=16.
REQ-033 One sub-module, seq_timer: a loadable down-counter with a zero flag, instantiated once for ON/OFF durations.

Verification (ON_CYCLES=3, OFF_CYCLES=2)
REQ-034 data=64'hA000_0000_0000_4321, len=3, start pulse:
- led sequence 1,1,1,0,0,2,2,2,0,0,3,3,3,0,0,4,4,4,0,0;
- busy high 20 cycles, then done=1 for 1 cycle;
- mvp=4'hA.
REQ-035 len=15, data=64'hFEDC_BA98_7654_3210:
- 16 elements 0..F in order;
- step wraps to 0 only after DONE;
- busy high 80 cycles.
REQ-036 abort in the 2nd cycle of the element-1 ON:
- next cycle IDLE, led=0, busy=0;
- done stays 0.
REQ-037 R low mid-OFF of element 2:
- all outputs 0 asynchronously (before the next clk edge);
- start after release plays from element 0.
REQ-038 start held high through playback, with data changed mid-run:
- the second run starts only after DONE;
- the first run uses the originally captured word.
REQ-039 SEQ_PLAYBACK_GAP_EN undefined, len=1, data=64'h21:
- led 1,1,1,2,2,2;
- done on cycle 7.
